// File: rtl/mem_latency_injector_mo.sv
// Multi-outstanding memory latency injector: tags requests with a per-request latency
// (SRAM/DRAM base, LFSR-driven DRAM hit, optional bandwidth term) and returns them in order.
module mem_latency_injector_mo #(
    parameter int          SIZE_WIDTH          = 16,
    parameter int          ID_WIDTH            = 4,
    parameter int          DEPTH               = 8,
    parameter int          LAT_WIDTH           = 16,
    parameter int          LATENCY_SRAM_CYCLES = 2,
    parameter int          LATENCY_DRAM_CYCLES = 30,
    parameter int          BW_SRAM_LOG2        = 6,
    parameter int          BW_DRAM_LOG2        = 4,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_is_dram,
    input  logic [SIZE_WIDTH-1:0]     req_size_bytes,
    input  logic [ID_WIDTH-1:0]       req_id,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_WIDTH-1:0]       resp_id,
    output logic [SIZE_WIDTH-1:0]     resp_size_bytes,
    output logic                      resp_was_hit,
    input  logic [15:0]               cfg_latency_sram,
    input  logic [15:0]               cfg_latency_dram,
    input  logic                      cfg_use_cfg_latencies,
    input  logic [9:0]                cfg_dram_hit_milli_pct,
    input  logic                      cfg_bw_enable,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               total_reqs,
    output logic [31:0]               total_resp,
    output logic [31:0]               dram_hits,
    output logic [31:0]               stall_cycles,
    output logic                      busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = ((LAT_WIDTH > SIZE_WIDTH) ? LAT_WIDTH : SIZE_WIDTH) + 18;
    localparam logic [SUM_W-1:0] LAT_MAX = SUM_W'({LAT_WIDTH{1'b1}});

    function automatic logic [SUM_W-1:0] ceil_shift(input logic [SIZE_WIDTH-1:0] size, input int sh);
        logic [SUM_W-1:0] round_v;
        round_v = (SUM_W'(1) << sh) - SUM_W'(1);
        return (SUM_W'(size) + round_v) >> sh;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    logic [ID_WIDTH-1:0]   id_q   [DEPTH];
    logic [SIZE_WIDTH-1:0] size_q [DEPTH];
    logic                  hit_q  [DEPTH];
    logic [LAT_WIDTH-1:0]  cnt_q  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      count_q, count_d;
    logic                  req_ready_q, resp_valid_q, resp_valid_d, resp_hit_q, busy_q;
    logic [ID_WIDTH-1:0]   resp_id_q;
    logic [SIZE_WIDTH-1:0] resp_size_q;
    logic [15:0]           lfsr_q;
    logic [31:0]           total_reqs_q, total_resp_q, dram_hits_q, stall_q;

    logic                  accept_s, pop_s, hit_s, present_s;
    logic [PTR_W-1:0]      present_ptr_s;
    logic [15:0]           sram_lat_s, dram_lat_s;
    logic [25:0]           product_s;
    logic [SUM_W-1:0]      lat_sum_s;
    logic [LAT_WIDTH-1:0]  lat_s;

    assign accept_s = req_valid & req_ready_q;
    assign pop_s    = resp_valid_q & resp_ready;

    // Latency of the request offered this cycle, fixed at acceptance
    always_comb begin
        if (cfg_use_cfg_latencies) begin
            sram_lat_s = at_least_one(cfg_latency_sram);
            dram_lat_s = at_least_one(cfg_latency_dram);
        end else begin
            sram_lat_s = at_least_one(16'(LATENCY_SRAM_CYCLES));
            dram_lat_s = at_least_one(16'(LATENCY_DRAM_CYCLES));
        end
        // product[25:16] < milli is the same test as product < milli<<16
        product_s = {10'd0, lfsr_q} * 26'd1000;
        hit_s     = req_is_dram & (product_s < {cfg_dram_hit_milli_pct, 16'h0000});
        if (!req_is_dram || hit_s) begin
            lat_sum_s = SUM_W'(sram_lat_s);
            if (cfg_bw_enable) begin
                lat_sum_s = lat_sum_s + ceil_shift(req_size_bytes, BW_SRAM_LOG2);
            end else begin
                lat_sum_s = lat_sum_s;
            end
        end else begin
            lat_sum_s = SUM_W'(dram_lat_s);
            if (cfg_bw_enable) begin
                lat_sum_s = lat_sum_s + ceil_shift(req_size_bytes, BW_DRAM_LOG2);
            end else begin
                lat_sum_s = lat_sum_s;
            end
        end
        if (lat_sum_s > LAT_MAX) begin
            lat_s = {LAT_WIDTH{1'b1}};
        end else begin
            lat_s = lat_sum_s[LAT_WIDTH-1:0];
        end
    end

    // Response presentation: an entry is eligible at the edge its counter leaves 1
    always_comb begin
        present_s     = 1'b0;
        present_ptr_s = rd_ptr_q;
        if (pop_s) begin
            present_ptr_s = rd_ptr_q + PTR_W'(1);
            present_s     = (count_q >= OCC_W'(2)) && (cnt_q[present_ptr_s] <= LAT_WIDTH'(1));
        end else if (!resp_valid_q) begin
            present_s     = (count_q != OCC_W'(0)) && (cnt_q[rd_ptr_q] <= LAT_WIDTH'(1));
        end else begin
            present_s     = 1'b0;
        end
        resp_valid_d = (resp_valid_q & ~pop_s) | present_s;
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage, pointers, response registers and telemetry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                size_q[i] <= '0;
                hit_q[i]  <= 1'b0;
                cnt_q[i]  <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_size_q  <= '0;
            resp_hit_q   <= 1'b0;
            busy_q       <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            total_reqs_q <= 32'd0;
            total_resp_q <= 32'd0;
            dram_hits_q  <= 32'd0;
            stall_q      <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept_s && (wr_ptr_q == PTR_W'(i))) begin
                    cnt_q[i] <= lat_s;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - LAT_WIDTH'(1);
                end
            end
            if (accept_s) begin
                id_q[wr_ptr_q]   <= req_id;
                size_q[wr_ptr_q] <= req_size_bytes;
                hit_q[wr_ptr_q]  <= hit_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                total_reqs_q     <= total_reqs_q + 32'd1;
                if (hit_s) begin
                    dram_hits_q <= dram_hits_q + 32'd1;
                end
                if (req_is_dram) begin
                    lfsr_q <= lfsr_step(lfsr_q);
                end
            end
            if (pop_s) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                total_resp_q <= total_resp_q + 32'd1;
            end
            if (resp_valid_q && !resp_ready) begin
                stall_q <= stall_q + 32'd1;
            end
            if (present_s) begin
                resp_id_q   <= id_q[present_ptr_s];
                resp_size_q <= size_q[present_ptr_s];
                resp_hit_q  <= hit_q[present_ptr_s];
            end
            count_q      <= count_d;
            req_ready_q  <= (count_d < OCC_W'(DEPTH));
            busy_q       <= (count_d != OCC_W'(0));
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_id         = resp_id_q;
    assign resp_size_bytes = resp_size_q;
    assign resp_was_hit    = resp_hit_q;
    assign occupancy       = count_q;
    assign busy            = busy_q;
    assign total_reqs      = total_reqs_q;
    assign total_resp      = total_resp_q;
    assign dram_hits       = dram_hits_q;
    assign stall_cycles    = stall_q;
endmodule

// File: tb/tb_mem_latency_injector_mo.sv
// Directed bench for mem_latency_injector_mo: latency, ordering, backpressure, hit and reset scenarios.
module tb_mem_latency_injector_mo;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_is_dram;
    logic [15:0] req_size_bytes;
    logic [3:0]  req_id;
    logic        resp_valid, resp_ready, resp_was_hit;
    logic [3:0]  resp_id;
    logic [15:0] resp_size_bytes;
    logic [15:0] cfg_latency_sram, cfg_latency_dram;
    logic        cfg_use_cfg_latencies, cfg_bw_enable;
    logic [9:0]  cfg_dram_hit_milli_pct;
    logic [3:0]  occupancy;
    logic [31:0] total_reqs, total_resp, dram_hits, stall_cycles;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_latency_injector_mo dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_dram(req_is_dram),
        .req_size_bytes(req_size_bytes), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_size_bytes(resp_size_bytes), .resp_was_hit(resp_was_hit),
        .cfg_latency_sram(cfg_latency_sram), .cfg_latency_dram(cfg_latency_dram),
        .cfg_use_cfg_latencies(cfg_use_cfg_latencies),
        .cfg_dram_hit_milli_pct(cfg_dram_hit_milli_pct), .cfg_bw_enable(cfg_bw_enable),
        .occupancy(occupancy), .total_reqs(total_reqs), .total_resp(total_resp),
        .dram_hits(dram_hits), .stall_cycles(stall_cycles), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic dram, input logic [15:0] size, input logic [3:0] id);
        req_valid = 1'b1; req_is_dram = dram; req_size_bytes = size; req_id = id;
        tick();
        req_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until resp_valid is seen; bounded
    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
        checks++; if (occupancy !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_occ got %0d/%0b exp 0/0", occupancy, busy); end
        checks++; if ((total_reqs | total_resp | dram_hits | stall_cycles) !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d %0d %0d %0d exp 0", total_reqs, total_resp, dram_hits, stall_cycles); end
    endtask

    task automatic test_default_latency();
        int n;
        cfg_use_cfg_latencies = 1'b0; cfg_bw_enable = 1'b0; cfg_dram_hit_milli_pct = 10'd0; resp_ready = 1'b1;
        send(1'b0, 16'd64, 4'd5);
        wait_resp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL sram_default_lat got %0d exp 2", n); end
        checks++; if (resp_id !== 4'd5 || resp_size_bytes !== 16'd64) begin errors++; $display("FAIL sram_echo got id %0d size %0d exp 5 64", resp_id, resp_size_bytes); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sram_pop got %0b exp 0", resp_valid); end
        send(1'b1, 16'd64, 4'd9);
        wait_resp(n);
        checks++; if (n !== 30) begin errors++; $display("FAIL dram_default_lat got %0d exp 30", n); end
        checks++; if (resp_id !== 4'd9) begin errors++; $display("FAIL dram_echo got %0d exp 9", resp_id); end
        tick();
    endtask

    task automatic test_back_to_back();
        cfg_use_cfg_latencies = 1'b1; cfg_latency_sram = 16'd5; cfg_latency_dram = 16'd10;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_is_dram = 1'b0; req_size_bytes = 16'd16; req_id = 4'(i);
            tick();
        end
        req_valid = 1'b0;
        checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL b2b_peak_occ got %0d exp 4", occupancy); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %0b exp 0", resp_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_id !== 4'(i)) begin errors++; $display("FAIL b2b_resp%0d got v%0b id %0d exp v1 id %0d", i, resp_valid, resp_id, i); end
        end
        tick();
        checks++; if (resp_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL b2b_drained got v%0b occ %0d exp 0 0", resp_valid, occupancy); end
    endtask

    task automatic test_ordering();
        int n;
        cfg_dram_hit_milli_pct = 10'd0;
        req_valid = 1'b1; req_is_dram = 1'b1; req_size_bytes = 16'd8; req_id = 4'd7;
        tick();
        req_is_dram = 1'b0; req_id = 4'd8;
        tick();
        req_valid = 1'b0;
        wait_resp(n);
        checks++; if (n !== 9 || resp_id !== 4'd7) begin errors++; $display("FAIL order_head got n %0d id %0d exp 9 7", n, resp_id); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 4'd8) begin errors++; $display("FAIL order_next got v%0b id %0d exp v1 8", resp_valid, resp_id); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %0b exp 0", resp_valid); end
    endtask

    task automatic test_full_backpressure();
        logic [31:0] tr0, tp0, s0;
        resp_ready = 1'b0;
        tr0 = total_reqs; tp0 = total_resp;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_is_dram = 1'b0; req_size_bytes = 16'd4; req_id = 4'(i);
            tick();
        end
        checks++; if (req_ready !== 1'b0 || occupancy !== 4'd8) begin errors++; $display("FAIL full_ready got rdy %0b occ %0d exp 0 8", req_ready, occupancy); end
        req_id = 4'd8;
        tick();
        req_valid = 1'b0;
        checks++; if (occupancy !== 4'd8 || total_reqs !== tr0 + 32'd8) begin errors++; $display("FAIL full_reject got occ %0d reqs %0d exp 8 %0d", occupancy, total_reqs, tr0 + 32'd8); end
        s0 = stall_cycles;
        repeat (3) tick();
        checks++; if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL stall_count got %0d exp %0d", stall_cycles, s0 + 32'd3); end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 4'd0) begin errors++; $display("FAIL stall_hold got v%0b id %0d exp v1 0", resp_valid, resp_id); end
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_id !== 4'(i)) begin errors++; $display("FAIL drain%0d got v%0b id %0d exp v1 id %0d", i, resp_valid, resp_id, i); end
            tick();
            if (i == 0) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_return got %0b exp 1", req_ready); end
            end
        end
        checks++; if (resp_valid !== 1'b0 || occupancy !== 4'd0 || total_resp !== tp0 + 32'd8) begin errors++; $display("FAIL drain_done got v%0b occ %0d resp %0d exp 0 0 %0d", resp_valid, occupancy, total_resp, tp0 + 32'd8); end
    endtask

    task automatic test_hit();
        int n;
        logic [31:0] h0;
        h0 = dram_hits;
        cfg_dram_hit_milli_pct = 10'd1000;
        send(1'b1, 16'd32, 4'd3);
        wait_resp(n);
        checks++; if (n !== 5 || resp_was_hit !== 1'b1) begin errors++; $display("FAIL hit_always got n %0d hit %0b exp 5 1", n, resp_was_hit); end
        checks++; if (dram_hits !== h0 + 32'd1) begin errors++; $display("FAIL hit_count got %0d exp %0d", dram_hits, h0 + 32'd1); end
        tick();
        cfg_dram_hit_milli_pct = 10'd0;
        send(1'b1, 16'd32, 4'd4);
        wait_resp(n);
        checks++; if (n !== 10 || resp_was_hit !== 1'b0 || dram_hits !== h0 + 32'd1) begin errors++; $display("FAIL hit_never got n %0d hit %0b cnt %0d exp 10 0 %0d", n, resp_was_hit, dram_hits, h0 + 32'd1); end
        tick();
    endtask

    task automatic test_bw_and_reset();
        int n;
        int stale;
        cfg_bw_enable = 1'b1; cfg_latency_sram = 16'd2;
        send(1'b0, 16'd256, 4'd6);
        wait_resp(n);
        checks++; if (n !== 6) begin errors++; $display("FAIL bw_sram256 got %0d exp 6", n); end
        tick();
        send(1'b0, 16'd65, 4'd6);
        wait_resp(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bw_sram65_ceil got %0d exp 4", n); end
        tick();
        send(1'b1, 16'd256, 4'd2);
        wait_resp(n);
        checks++; if (n !== 26) begin errors++; $display("FAIL bw_dram256 got %0d exp 26", n); end
        tick();
        cfg_bw_enable = 1'b0; cfg_latency_sram = 16'd5;
        for (int i = 0; i < 3; i++) send(1'b1, 16'd8, 4'(i));
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL pre_reset_occ got %0d exp 3", occupancy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || total_reqs !== 32'd0) begin errors++; $display("FAIL async_reset got occ %0d busy %0b rdy %0b v %0b reqs %0d exp 0 0 1 0 0", occupancy, busy, req_ready, resp_valid, total_reqs); end
        tick();
        #3 reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid !== 1'b0) stale++;
        end
        checks++; if (stale !== 0 || occupancy !== 4'd0) begin errors++; $display("FAIL stale_after_reset got %0d cycles occ %0d exp 0 0", stale, occupancy); end
    endtask

    // LFSR restarts at 0xACE1 (frac 675), next state 0xE270 (frac 884)
    task automatic test_hit_boundary();
        int n;
        cfg_dram_hit_milli_pct = 10'd675;
        send(1'b1, 16'd8, 4'd1);
        wait_resp(n);
        checks++; if (n !== 10 || resp_was_hit !== 1'b0) begin errors++; $display("FAIL hit_edge_miss got n %0d hit %0b exp 10 0", n, resp_was_hit); end
        tick();
        cfg_dram_hit_milli_pct = 10'd885;
        send(1'b1, 16'd8, 4'd2);
        wait_resp(n);
        checks++; if (n !== 5 || resp_was_hit !== 1'b1 || dram_hits !== 32'd1) begin errors++; $display("FAIL hit_edge_hit got n %0d hit %0b cnt %0d exp 5 1 1", n, resp_was_hit, dram_hits); end
        tick();
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_is_dram = 1'b0; req_size_bytes = 16'd0; req_id = 4'd0;
        resp_ready = 1'b1; cfg_latency_sram = 16'd0; cfg_latency_dram = 16'd0;
        cfg_use_cfg_latencies = 1'b0; cfg_dram_hit_milli_pct = 10'd0; cfg_bw_enable = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        test_reset();
        test_default_latency();
        test_back_to_back();
        test_ordering();
        test_full_backpressure();
        test_hit();
        test_bw_and_reset();
        test_hit_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_latency_injector_mo.md
Name: mem_latency_injector_mo

Overview:
Multi-outstanding successor to memory_latency_injector. It accepts up to DEPTH in-flight requests, each tagged with an ID. Each request gets a per-request latency from SRAM/DRAM base, a probabilistic DRAM hit, and an optional size-proportional bandwidth term. Responses return in order with resp_ready backpressure. It sits between the NPU DMA/compute request ports and the memory model, for performance-model simulation.

Parameters:
SIZE_WIDTH, 16, request size field width (bytes)
ID_WIDTH, 4, request tag width
DEPTH, 8, max in-flight requests (power of two, >=2)
LAT_WIDTH, 16, latency counter width
LATENCY_SRAM_CYCLES, 2, default SRAM latency
LATENCY_DRAM_CYCLES, 30, default DRAM latency
BW_SRAM_LOG2, 6, log2 SRAM bytes/cycle for the bandwidth term
BW_DRAM_LOG2, 4, log2 DRAM bytes/cycle for the bandwidth term
LFSR_SEED, 16'hACE1, hit-decision LFSR reset value (nonzero)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_is_dram  in  1  1=DRAM, 0=SRAM
req_size_bytes  in  SIZE_WIDTH  transfer size
req_id  in  ID_WIDTH  request tag
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  ID_WIDTH  tag of head response
resp_size_bytes  out  SIZE_WIDTH  size of head response
resp_was_hit  out  1  DRAM request took the SRAM (hit) latency
cfg_latency_sram  in  16  override SRAM latency
cfg_latency_dram  in  16  override DRAM latency
cfg_use_cfg_latencies  in  1  1=use cfg latencies, 0=parameters
cfg_dram_hit_milli_pct  in  10  DRAM hit probability, 0..1000
cfg_bw_enable  in  1  add the bandwidth term
occupancy  out  $clog2(DEPTH)+1  entries in flight
total_reqs  out  32  accepted requests
total_resp  out  32  completed responses
dram_hits  out  32  DRAM requests resolved as hits
stall_cycles  out  32  cycles with resp_valid & !resp_ready
busy  out  1  occupancy != 0

Behaviour:
- Reset (async assert, sync release): all entries invalid; all outputs 0 except req_ready=1; counters 0; LFSR=LFSR_SEED. A reset mid-flight discards in-flight requests silently.
- req_ready = (occupancy < DEPTH). Registered, no combinational path from resp_ready. When full, a same-cycle pop does not allow an accept.
- Accept at edge k when req_valid & req_ready. The entry captures id, size, is_dram, hit and latency L.
- Base latency: SRAM → sram_lat. DRAM hit → sram_lat. DRAM miss → dram_lat. sram_lat/dram_lat come from cfg_* if cfg_use_cfg_latencies, else from parameters. A value of 0 is treated as 1.
- Hit decision, DRAM only:
  - product = lfsr*1000, hit = product[25:16] < cfg_dram_hit_milli_pct.
  - 0 → never hit; >=1000 → always hit.
  - LFSR is a 16-bit Galois LFSR (taps 16,14,13,11). It advances only on accepted DRAM requests, after sampling.
- Bandwidth term, when cfg_bw_enable: L += ceil(size >> BW_x_LOG2), where x is SRAM for SRAM and hit paths and DRAM for misses.
- L saturates at 2^LAT_WIDTH-1.
- Timing:
  - Each valid entry's remaining counter decrements every cycle and saturates at 0.
  - Entry accepted at edge k is eligible after edge k+L.
  - The head (oldest) entry drives resp_valid once eligible. resp_valid, resp_id, resp_size_bytes and resp_was_hit are registered.
  - Pop on resp_valid & resp_ready; the next eligible head presents on the following cycle, allowing back-to-back one response per cycle.
  - Younger entries that become eligible before the head wait; ordering is strictly FIFO.
- resp_valid, once high, holds with stable payload until accepted.
- Occupancy update:
  - Accept and pop in the same cycle: occupancy unchanged, total_reqs and total_resp both increment.
  - Pointers wrap modulo DEPTH.
- Telemetry: 32-bit counters wrap; dram_hits increments at accept; stall_cycles counts resp_valid & !resp_ready.
- Config changes affect only requests accepted after the change; in-flight latencies are fixed at acceptance.

Test Plan:
1. Defaults, bw off: SRAM 64B accepted at edge k → resp_valid first high after edge k+2. DRAM → after k+30. resp_id echoes the request ID.
2. cfg_use_cfg_latencies=1, sram=5, dram=10; four back-to-back SRAM requests IDs 0..3 from edge k → responses after k+5..k+8, consecutive cycles, IDs in order; occupancy peaks at 4.
3. DRAM (lat 10) then SRAM (lat 5) one cycle apart → SRAM held until DRAM pops after k+10; SRAM returns the next cycle; order preserved.
4. resp_ready=0, 9 requests with DEPTH=8 → req_ready=0 after the 8th; stall_cycles increments per held cycle; releasing resp_ready drains 8 responses in 8 cycles; req_ready returns.
5. hit_milli=1000 → DRAM latency = sram_lat, resp_was_hit=1, dram_hits=1. hit_milli=0 → DRAM latency, dram_hits unchanged.
6. cfg_bw_enable=1, sram=2, SRAM 256B → L=2+4=6. Assert reset_n=0 with 3 in flight → outputs clear immediately; no stale response after release.
